// File: rtl/pci_cfg_pkg.sv
// Shared constants and helpers for the Type-0 PCI configuration header.
// Offsets are dword indices; masks mark the software-writable bits.
package pci_cfg_pkg;

   localparam logic [5:0] CFG_ID      = 6'h00;
   localparam logic [5:0] CFG_CMDSTAT = 6'h01;
   localparam logic [5:0] CFG_CLASS   = 6'h02;
   localparam logic [5:0] CFG_HDR     = 6'h03;
   localparam logic [5:0] CFG_BAR0    = 6'h04;
   localparam logic [5:0] CFG_SUBSYS  = 6'h0B;
   localparam logic [5:0] CFG_INTR    = 6'h0F;

   localparam int CMD_IO_EN   = 0;
   localparam int CMD_MEM_EN  = 1;
   localparam int CMD_BUS_MST = 2;
   localparam int CMD_PERR    = 6;
   localparam int CMD_SERR    = 8;
   localparam int CMD_INT_DIS = 10;

   localparam int ST_INT  = 19;
   localparam int ST_MDPE = 24;
   localparam int ST_STA  = 27;
   localparam int ST_RTA  = 28;
   localparam int ST_RMA  = 29;
   localparam int ST_SSE  = 30;
   localparam int ST_DPE  = 31;

   localparam logic [1:0] DEVSEL_SLOW = 2'b10;

   localparam logic [31:0] MASK_CMD  = 32'h0000_0547;
   localparam logic [31:0] MASK_W1C  = 32'hF900_0000;
   localparam logic [31:0] MASK_HDR  = 32'h0000_FFFF;
   localparam logic [31:0] MASK_INTR = 32'h0000_00FF;

   function automatic logic [31:0] be_merge(
      input logic [31:0] old_v,
      input logic [31:0] new_v,
      input logic [3:0]  be,
      input logic [31:0] mask
   );
      logic [31:0] m;
      m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}} & mask;
      return (old_v & ~m) | (new_v & m);
   endfunction

endpackage

// File: rtl/pci_cfgspace_if.sv
// Configuration access port between the bus interface and the header.
// The bus side (master) issues accesses; the header (slave) returns data.
interface pci_cfgspace_if;

   logic        cfg_enable;
   logic        cfg_iswrite;
   logic [5:0]  cfg_offset;
   logic [3:0]  cfg_byte_en;
   logic [31:0] cfg_write_val;
   logic [31:0] cfg_read_val;

   modport master (
      output cfg_enable,
      output cfg_iswrite,
      output cfg_offset,
      output cfg_byte_en,
      output cfg_write_val,
      input  cfg_read_val
   );

   modport slave (
      input  cfg_enable,
      input  cfg_iswrite,
      input  cfg_offset,
      input  cfg_byte_en,
      input  cfg_write_val,
      output cfg_read_val
   );

endinterface

// File: rtl/pci_cfgspace.sv
// Type-0 PCI configuration header: registered reads, byte-enabled writes,
// RW1C error status and exported command/BAR/interrupt fields.
module pci_cfgspace
   import pci_cfg_pkg::*;
#(
   parameter logic [15:0] VENDOR_ID      = 16'h1234,
   parameter logic [15:0] DEVICE_ID      = 16'h0001,
   parameter logic [7:0]  REVISION_ID    = 8'h00,
   parameter logic [23:0] CLASS_CODE     = 24'hFF0000,
   parameter logic [15:0] SUBSYS_VID     = 16'h0000,
   parameter logic [15:0] SUBSYS_ID      = 16'h0000,
   parameter int unsigned BAR0_SIZE_LOG2 = 12,
   parameter logic [7:0]  INT_PIN        = 8'h01
) (
   input  logic                 clk,
   input  logic                 rst,
   pci_cfgspace_if.slave        cfg,
   input  logic [5:0]           err_set,
   input  logic                 int_pending,
   output logic                 cmd_io_en,
   output logic                 cmd_mem_en,
   output logic                 cmd_bus_master,
   output logic                 cmd_perr_resp,
   output logic                 cmd_serr_en,
   output logic                 cmd_int_dis,
   output logic [31:0]          bar0_base,
   output logic [7:0]           int_line,
   output logic [7:0]           latency_timer
);

   localparam logic [31:0] BAR_MASK =
      ~((32'h1 << BAR0_SIZE_LOG2) - 32'h1);

   logic        w_wr;
   logic        w_rd;
   logic [31:0] w_rdata;
   logic [15:0] w_status;
   logic [5:0]  w_clr;

   logic [31:0] r_cmd;
   logic [5:0]  r_err;
   logic [31:0] r_hdr;
   logic [31:0] r_bar;
   logic [31:0] r_intr;

   assign w_wr = cfg.cfg_enable & cfg.cfg_iswrite;
   assign w_rd = cfg.cfg_enable & ~cfg.cfg_iswrite;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cmd <= '0;
      end else if (w_wr && cfg.cfg_offset == CFG_CMDSTAT) begin
         r_cmd <= be_merge(r_cmd, cfg.cfg_write_val,
                           cfg.cfg_byte_en, MASK_CMD);
      end
   end

   // All error bits sit in byte lane 3 of the command/status dword.
   assign w_clr = {6{w_wr && cfg.cfg_offset == CFG_CMDSTAT
                     && cfg.cfg_byte_en[3]}}
                & {cfg.cfg_write_val[ST_DPE:ST_STA],
                   cfg.cfg_write_val[ST_MDPE]};

   // Set after clear so a same-cycle event is never lost.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_err <= '0;
      end else begin
         r_err <= (r_err & ~w_clr) | err_set;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hdr <= '0;
      end else if (w_wr && cfg.cfg_offset == CFG_HDR) begin
         r_hdr <= be_merge(r_hdr, cfg.cfg_write_val,
                           cfg.cfg_byte_en, MASK_HDR);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_bar <= '0;
      end else if (w_wr && cfg.cfg_offset == CFG_BAR0) begin
         r_bar <= be_merge(r_bar, cfg.cfg_write_val,
                           cfg.cfg_byte_en, BAR_MASK);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_intr <= '0;
      end else if (w_wr && cfg.cfg_offset == CFG_INTR) begin
         r_intr <= be_merge(r_intr, cfg.cfg_write_val,
                            cfg.cfg_byte_en, MASK_INTR);
      end
   end

   assign w_status = {r_err[5:1], DEVSEL_SLOW, r_err[0],
                      4'h0, int_pending, 3'h0};

   always_comb begin
      w_rdata = '0;
      case (cfg.cfg_offset)
         CFG_ID:      w_rdata = {DEVICE_ID, VENDOR_ID};
         CFG_CMDSTAT: w_rdata = {w_status, 16'h0} | r_cmd;
         CFG_CLASS:   w_rdata = {CLASS_CODE, REVISION_ID};
         CFG_HDR:     w_rdata = r_hdr;
         CFG_BAR0:    w_rdata = r_bar;
         CFG_SUBSYS:  w_rdata = {SUBSYS_ID, SUBSYS_VID};
         CFG_INTR:    w_rdata = {16'h0, INT_PIN, 8'h0} | r_intr;
         default:     w_rdata = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cfg.cfg_read_val <= '0;
      end else if (w_rd) begin
         cfg.cfg_read_val <= w_rdata;
      end
   end

   assign cmd_io_en      = r_cmd[CMD_IO_EN];
   assign cmd_mem_en     = r_cmd[CMD_MEM_EN];
   assign cmd_bus_master = r_cmd[CMD_BUS_MST];
   assign cmd_perr_resp  = r_cmd[CMD_PERR];
   assign cmd_serr_en    = r_cmd[CMD_SERR];
   assign cmd_int_dis    = r_cmd[CMD_INT_DIS];
   assign bar0_base      = r_bar;
   assign int_line       = r_intr[7:0];
   assign latency_timer  = r_hdr[15:8];

endmodule

// File: doc/pci_cfgspace.md
# pci_cfgspace

Type-0 PCI configuration header register file behind the bus interface's `cfg_*` port. It decodes dword-offset accesses, returns read data one cycle after the request, and applies byte-enabled writes to the writable header fields. It exports the decoded command bits, the BAR0 base and the interrupt line to the rest of the device. It collects error/interrupt events into the status register.

## Interface
- `VENDOR_ID`, 16'h1234: offset 0x00 [15:0], RO
- `DEVICE_ID`, 16'h0001: offset 0x00 [31:16], RO
- `REVISION_ID`, 8'h00; `CLASS_CODE`, 24'hFF0000: offset 0x02 [7:0] / [31:8], RO
- `SUBSYS_VID`, 16'h0000; `SUBSYS_ID`, 16'h0000: offset 0x0B, RO
- `BAR0_SIZE_LOG2`, 12: BAR0 memory window size 2^N bytes; legal range 4..31
- `INT_PIN`, 8'h01: offset 0x0F [15:8]; 0 = no interrupt
- `clk`  in  1: bus clock
- `rst`  in  1: asynchronous, active-low reset
- `cfg_enable`  in  1: access strobe, one cycle per access
- `cfg_iswrite`  in  1: 1 = write, 0 = read; qualified by `cfg_enable`
- `cfg_offset`  in  6: dword offset 0x00–0x3F
- `cfg_byte_en`  in  4: active-high byte lanes, writes only
- `cfg_write_val`  in  32: write data
- `cfg_read_val`  out  32: registered read data
- `err_set`  in  6: single-cycle event pulses: [0] master data parity error, [1] signalled target abort, [2] received target abort, [3] received master abort, [4] signalled SERR, [5] detected parity error
- `int_pending`  in  1: level; function-internal interrupt condition
- `cmd_io_en`, `cmd_mem_en`, `cmd_bus_master`, `cmd_perr_resp`, `cmd_serr_en`, `cmd_int_dis`  out  1 each: command register bits 0, 1, 2, 6, 8, 10
- `bar0_base`  out  32: BAR0 value; low `BAR0_SIZE_LOG2` bits are 0
- `int_line`  out  8: offset 0x0F [7:0]
- `latency_timer`  out  8: offset 0x03 [15:8]

## Operation
- Read: `cfg_enable & ~cfg_iswrite` at edge N loads `cfg_read_val` at edge N. The value is held until the next read. Writes never change `cfg_read_val`.
- Write: `cfg_enable & cfg_iswrite` at edge N updates the writable bits in enabled lanes at edge N. RO bits ignore writes.
- Register map:
  - 0x01 command [15:0]: only bits 0, 1, 2, 6, 8 and 10 are writable; all other bits read 0.
  - 0x01 status [31:16]:
    - bit 19 = `int_pending` (live, RO).
    - bits 26:25 = 2'b10 (slow DEVSEL).
    - bits 24, 27, 28, 29, 30, 31 are RW1C, set by `err_set[0..5]`.
    - All other status bits read 0.
  - 0x03: cache line size [7:0] and latency timer [15:8] are RW; header type and BIST read 0.
  - 0x04 BAR0: bits [31:BAR0_SIZE_LOG2] are RW; bits [3:0] read 0000 (32-bit, non-prefetchable memory).
  - 0x0F: int_line [7:0] is RW; int_pin comes from the parameter; min_gnt and max_lat read 0.
  - 0x05–0x0A, 0x0C–0x0E and 0x10–0x3F read 0; writes are ignored.
- An RW1C set event in the same cycle as a write-1 clear leaves the bit at 1 (set wins).
- `int_pending` is not gated by `cmd_int_dis`; gating happens at the INTx driver.
- All outputs are direct register copies. No combinational path from `cfg_*` inputs to outputs.

## Timing
- Reset: all RW and RW1C bits = 0; `cfg_read_val` = 0; all `cmd_*` = 0; `bar0_base`, `int_line` and `latency_timer` = 0.
- Read latency is 1 cycle. The bus interface samples `cfg_read_val` 2 cycles after `cfg_enable`, and the value must still be valid then.
- Write followed by a read on the next cycle returns the new value.
- A `rst` assertion mid-access aborts the access. No partial write survives.
- `cfg_offset` and `cfg_byte_en` are don't-care when `cfg_enable` = 0.

## Structure
- Package `pci_cfg_pkg` holds:
  - dword offset constants (`CFG_ID`, `CFG_CMDSTAT`, `CFG_CLASS`, `CFG_HDR`, `CFG_BAR0`, `CFG_SUBSYS`, `CFG_INTR`);
  - command and status bit-index constants;
  - writable-mask constants;
  - a byte-lane merge function (old, new, be, mask).
- Single module, no sub-modules. One always_ff per register group plus a registered read mux.

## Test plan
- Reset, then read 0x00 -> 32'h0001_1234 one cycle later; read 0x01 -> 32'h0400_0000.
- Write 0x01 = 32'hFFFF_FFFF with be 4'b0011 -> reads back 32'h0400_0547; `cmd_io_en`, `cmd_mem_en`, `cmd_bus_master`, `cmd_perr_resp`, `cmd_serr_en` and `cmd_int_dis` all = 1.
- BAR sizing: write 0x04 = 32'hFFFF_FFFF -> read 32'hFFFF_F000; write 32'hFEDC_B123 -> `bar0_base` = 32'hFEDC_B000.
- Pulse `err_set[3]`, read 0x01 -> bit 29 set. Write 32'h2000_0000 together with a new `err_set[3]` pulse -> bit stays 1. A later clean write clears it.
- Write 0x0F = 32'hFFFF_FF0B -> read 32'h0000_010B, `int_line` = 8'h0B. Raise `int_pending` -> 0x01 bit 19 reads 1.
- Write and read 0x20 -> read 0, no other register changes. Assert `rst` mid-write -> all outputs return to reset values asynchronously.
